rx_frame_decode: RTL

- Sits directly downstream of the sequence decoder; consumes its bit-level rx stream and feeds byte-level frames to the ISO/IEC 14443-3A layer.
- Strips and checks the odd parity bit after each byte (LSB first) and assembles 8-bit bytes.
- Passes partial final bytes (short frames, anticollision split bytes) with an explicit bit count.
- Flags parity, framing and upstream errors.

---
 rtl/iso14443a_pkg.sv | 16 +
 rtl/odd_parity8.sv | 9 +
 rtl/rx_frame_decode.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/iso14443a_pkg.sv
// Shared ISO/IEC 14443-3A framing definitions used by the rx frame decoder and tx frame encoder.
package iso14443a_pkg;

    localparam int BITS_PER_BYTE = 8;

    // out_data_bits value meaning "all eight bits valid"
    localparam logic [2:0] DATA_BITS_FULL = 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        DISCARD
    } rx_frame_state_t;

endpackage

// File: rtl/odd_parity8.sv
// Combinational odd-parity generator: parity makes the 9-bit word {parity, data} contain an odd number of ones.
module odd_parity8 (
    input  logic [7:0] data,
    output logic       parity
);

    assign parity = ~^data;

endmodule

// File: rtl/rx_frame_decode.sv
// Bit-to-byte frame decoder: strips and checks odd parity after each LSB-first byte,
// forwards partial final bytes with a bit count and flags parity/framing/upstream errors.
module rx_frame_decode
    import iso14443a_pkg::*;
#(
    parameter bit CHECK_PARITY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_soc,
    input  logic       in_eoc,
    input  logic       in_data,
    input  logic       in_data_valid,
    input  logic       in_error,
    output logic       out_soc,
    output logic       out_eoc,
    output logic [7:0] out_data,
    output logic [2:0] out_data_bits,
    output logic       out_data_valid,
    output logic       out_error
);

    rx_frame_state_t state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            eoc_pend_q, eoc_pend_d;
    logic            soc_q, soc_d;
    logic            eoc_q, eoc_d;
    logic [7:0]      data_q, data_d;
    logic [2:0]      bits_q, bits_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            par_exp;

    odd_parity8 u_par (
        .data   (shift_q),
        .parity (par_exp)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        eoc_pend_d = 1'b0;
        soc_d      = 1'b0;
        // a partial or parity-less last byte is followed by its end-of-frame one cycle later
        eoc_d      = eoc_pend_q;
        data_d     = '0;
        bits_d     = DATA_BITS_FULL;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (in_soc) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
            soc_d     = 1'b1;
        end else if (in_error && (state_q != IDLE)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                DATA: begin
                    if (in_eoc) begin
                        state_d = IDLE;
                        if (bit_cnt_q == 3'd0) begin
                            eoc_d = 1'b1;
                        end else begin
                            data_d     = shift_q;
                            bits_d     = bit_cnt_q;
                            valid_d    = 1'b1;
                            eoc_pend_d = 1'b1;
                        end
                    end else if (in_data_valid) begin
                        shift_d[bit_cnt_q] = in_data;
                        bit_cnt_d          = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'(BITS_PER_BYTE - 1)) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (in_eoc) begin
                        state_d    = IDLE;
                        data_d     = shift_q;
                        valid_d    = 1'b1;
                        err_d      = 1'b1;
                        eoc_pend_d = 1'b1;
                    end else if (in_data_valid) begin
                        if ((in_data == par_exp) || !CHECK_PARITY) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                            shift_d   = '0;
                            data_d    = shift_q;
                            valid_d   = 1'b1;
                        end else begin
                            state_d = DISCARD;
                            err_d   = 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    if (in_eoc) begin
                        state_d = IDLE;
                        eoc_d   = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            eoc_pend_q <= 1'b0;
            soc_q      <= 1'b0;
            eoc_q      <= 1'b0;
            data_q     <= '0;
            bits_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            eoc_pend_q <= eoc_pend_d;
            soc_q      <= soc_d;
            eoc_q      <= eoc_d;
            data_q     <= data_d;
            bits_q     <= bits_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    // The shifter is pure datapath; in_soc clears it before any frame uses it.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign out_soc        = soc_q;
    assign out_eoc        = eoc_q;
    assign out_data       = data_q;
    assign out_data_bits  = bits_q;
    assign out_data_valid = valid_q;
    assign out_error      = err_q;

endmodule
